// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths,
// reset PC and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_WAIT  = 2'd2,
    IF_HOLD  = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch stage bundle: instruction memory request/response channel plus the
// valid/ready hand-off to decode and the control-flow inputs.
// master = fetch stage, slave = memory / decode / control side.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ready_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              valid_o;
  logic              ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] inst_o;
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_target_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              halt_i;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i, ready_i,
           jump_en_i, jump_target_i, redirect_i, redirect_pc_i, halt_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i, ready_i,
           jump_en_i, jump_target_i, redirect_i, redirect_pc_i, halt_i
  );
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter with next-PC selection: redirect > jump > pc+4.
// Targets are word-aligned by clearing the two low bits; pc+4 wraps.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              advance_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] pc_o
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next-PC mux; advance_i is only high on a decode handshake.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ALIGN_MASK;
    end else if (advance_i) begin
      pc_d = jump_en_i ? (jump_target_i & ALIGN_MASK) : (pc_q + ADDR_W'(4));
    end
  end

  // PC register, loaded with the boot address on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// holds the returned word with its PC until decode takes it, and discards
// responses made stale by a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  if_state_e         state_q;
  logic              req_q;
  logic              valid_q;
  logic              drop_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_hold_q;
  logic [ADDR_W-1:0] pc;
  logic              handshake;

  // A redirect kills the held instruction in the same cycle.
  assign bus.valid_o     = valid_q & ~bus.redirect_i;
  assign handshake       = bus.valid_o & bus.ready_i;
  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = req_q ? pc : '0;
  assign bus.pc_o        = pc_hold_q;
  assign bus.inst_o      = inst_q;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (bus.redirect_i),
    .redirect_pc_i (bus.redirect_pc_i),
    .advance_i     (handshake),
    .jump_en_i     (bus.jump_en_i),
    .jump_target_i (bus.jump_target_i),
    .pc_o          (pc)
  );

  // Fetch FSM with registered request/valid flags and the held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IF_IDLE;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      pc_hold_q <= '0;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (bus.redirect_i || !bus.halt_i) begin
            state_q <= IF_FETCH;
            req_q   <= 1'b1;
          end
        end
        IF_FETCH: begin
          // A redirect before acceptance just retargets the address via pc.
          // Accepted and answered under a redirect: stay here and refetch.
          if (bus.imem_ready_i && !(bus.imem_rvalid_i && bus.redirect_i)) begin
            req_q <= 1'b0;
            if (bus.imem_rvalid_i) begin
              inst_q    <= bus.imem_rdata_i;
              pc_hold_q <= pc;
              valid_q   <= 1'b1;
              state_q   <= IF_HOLD;
            end else begin
              drop_q  <= bus.redirect_i;
              state_q <= IF_WAIT;
            end
          end
        end
        IF_WAIT: begin
          if (bus.imem_rvalid_i) begin
            if (drop_q || bus.redirect_i) begin
              drop_q  <= 1'b0;
              req_q   <= 1'b1;
              state_q <= IF_FETCH;
            end else begin
              inst_q    <= bus.imem_rdata_i;
              pc_hold_q <= pc;
              valid_q   <= 1'b1;
              state_q   <= IF_HOLD;
            end
          end else if (bus.redirect_i) begin
            drop_q <= 1'b1;
          end
        end
        IF_HOLD: begin
          if (bus.redirect_i || handshake) begin
            valid_q <= 1'b0;
            if (!bus.redirect_i && bus.halt_i) begin
              state_q <= IF_IDLE;
            end else begin
              req_q   <= 1'b1;
              state_q <= IF_FETCH;
            end
          end
        end
        default: begin
          state_q <= IF_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a latency-configurable memory responder,
// a transaction-level reference model checked every cycle, and hand-computed
// expectations for the main scenarios.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          mem_lat     = 0;
  logic [31:0] ebreak_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: word = address + 1000_0013, except the ebreak slot.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == ebreak_addr) return 32'h0010_0073;
    return a + 32'h1000_0013;
  endfunction

  // Memory responder: accepts when idle, answers mem_lat cycles after accept.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  always @(negedge clk) begin
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    if (pend) begin
      if (cnt == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = mem_word(pend_addr);
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end else if (bus.imem_req_o) begin
      bus.imem_ready_i = 1'b1;
      if (mem_lat == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = mem_word(bus.imem_addr_o);
      end else begin
        pend      = 1'b1;
        pend_addr = bus.imem_addr_o;
        cnt       = mem_lat - 1;
      end
    end
  end

  // Reference model: architectural PC, one outstanding fetch, one held word.
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_hpc = 32'h0, m_hinst = 32'h0, m_out_addr = 32'h0;
  logic        m_held = 1'b0, m_out = 1'b0, m_out_stale = 1'b0, m_halted = 1'b0;
  logic        exp_valid;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);
      chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
      chk("rst_pc_o", bus.pc_o, 32'h0);
      chk("rst_inst_o", bus.inst_o, 32'h0);
      m_pc = RST_PC; m_held = 1'b0; m_out = 1'b0; m_halted = 1'b0;
    end else begin
      exp_valid = m_held && !bus.redirect_i;
      chk("valid_o", {31'b0, bus.valid_o}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("pc_o", bus.pc_o, m_hpc);
        chk("inst_o", bus.inst_o, m_hinst);
      end
      if (bus.imem_req_o) chk("imem_addr_o", bus.imem_addr_o, m_pc);
      chk("one_outstanding", {31'b0, bus.imem_req_o & (m_out | m_held)}, 32'h0);
      if (m_halted) chk("req_after_halt", {31'b0, bus.imem_req_o}, 32'h0);
      if (bus.imem_req_o && bus.imem_ready_i) begin
        m_out = 1'b1; m_out_addr = m_pc; m_out_stale = 1'b0;
      end
      if (bus.redirect_i && m_out) m_out_stale = 1'b1;
      if (bus.imem_rvalid_i && m_out) begin
        if (!m_out_stale) begin
          m_held = 1'b1; m_hpc = m_out_addr; m_hinst = mem_word(m_out_addr);
        end
        m_out = 1'b0;
      end
      if (!bus.halt_i) m_halted = 1'b0;
      if (bus.redirect_i) begin
        m_pc = {bus.redirect_pc_i[31:2], 2'b00};
        m_held = 1'b0; m_halted = 1'b0;
      end else if (exp_valid && bus.ready_i) begin
        m_pc = bus.jump_en_i ? {bus.jump_target_i[31:2], 2'b00} : m_pc + 32'd4;
        m_held = 1'b0;
        if (bus.halt_i) m_halted = 1'b1;
      end
    end
  end

  task automatic wait_valid(input int max, input string nm);
    int n = 0;
    forever begin
      @(negedge clk); #2;
      if (bus.valid_o) break;
      n++;
      if (n >= max) begin
        n_checks++; n_errors++;
        $display("FAIL %s: valid_o timeout after %0d cycles", nm, max);
        break;
      end
    end
  endtask

  task automatic wait_req(input int max, input string nm);
    int n = 0;
    forever begin
      @(negedge clk); #2;
      if (bus.imem_req_o) break;
      n++;
      if (n >= max) begin
        n_checks++; n_errors++;
        $display("FAIL %s: imem_req_o timeout after %0d cycles", nm, max);
        break;
      end
    end
  endtask

  int nvalid;
  initial begin
    bus.ready_i = 1'b0; bus.jump_en_i = 1'b0; bus.jump_target_i = 32'h0;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0; bus.halt_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 chk("reset_valid", {31'b0, bus.valid_o}, 32'h0);

    // Reset release with zero-latency memory.
    @(negedge clk) rst = 1'b1;
    @(negedge clk); #2;
    chk("first_req", {31'b0, bus.imem_req_o}, 32'h1);
    chk("first_addr", bus.imem_addr_o, 32'h8000_0000);
    @(negedge clk); #2;
    chk("first_valid", {31'b0, bus.valid_o}, 32'h1);
    chk("first_pc", bus.pc_o, 32'h8000_0000);
    chk("first_inst", bus.inst_o, 32'h9000_0013);

    // Backpressure: five more cycles held stable, no new request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("bp_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("bp_pc", bus.pc_o, 32'h8000_0000);
      chk("bp_inst", bus.inst_o, 32'h9000_0013);
      chk("bp_no_req", {31'b0, bus.imem_req_o}, 32'h0);
    end

    // Sequential fetch, 3-cycle memory, decode always ready.
    @(negedge clk) begin mem_lat = 3; bus.ready_i = 1'b1; end
    wait_valid(20, "seq1");
    chk("seq_pc1", bus.pc_o, 32'h8000_0004);
    chk("seq_inst1", bus.inst_o, 32'h9000_0017);
    wait_valid(20, "seq2");
    chk("seq_pc2", bus.pc_o, 32'h8000_0008);
    chk("seq_inst2", bus.inst_o, 32'h9000_001B);
    @(negedge clk) bus.ready_i = 1'b0;
    wait_valid(20, "seq3");
    chk("seq_pc3", bus.pc_o, 32'h8000_000C);

    // Jump on handshake to a misaligned target.
    @(negedge clk) begin bus.ready_i = 1'b1; bus.jump_en_i = 1'b1; bus.jump_target_i = 32'h8000_0102; end
    @(negedge clk) begin bus.ready_i = 1'b0; bus.jump_en_i = 1'b0; bus.jump_target_i = 32'h0; end
    #2;
    chk("jump_req", {31'b0, bus.imem_req_o}, 32'h1);
    chk("jump_addr", bus.imem_addr_o, 32'h8000_0100);

    // Redirect while the jump fetch is outstanding.
    @(negedge clk) begin bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0201; end
    @(negedge clk) bus.redirect_i = 1'b0;
    wait_valid(30, "redirect");
    chk("redir_pc", bus.pc_o, 32'h8000_0200);
    chk("redir_inst", bus.inst_o, 32'h9000_0213);

    // ebreak at the next word, handed over with halt_i raised.
    ebreak_addr = 32'h8000_0204;
    @(negedge clk) bus.ready_i = 1'b1;
    @(negedge clk) bus.ready_i = 1'b0;
    wait_valid(20, "ebreak");
    chk("ebreak_pc", bus.pc_o, 32'h8000_0204);
    chk("ebreak_inst", bus.inst_o, 32'h0010_0073);
    @(negedge clk) begin bus.halt_i = 1'b1; bus.ready_i = 1'b1; end
    @(negedge clk) begin bus.ready_i = 1'b0; mem_lat = 5; end
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      chk("halt_no_req", {31'b0, bus.imem_req_o}, 32'h0);
      if (bus.valid_o) nvalid++;
    end
    chk("halt_no_valid", nvalid, 32'h0);

    // Resume, then reset in the middle of the slow fetch.
    @(negedge clk) bus.halt_i = 1'b0;
    wait_req(10, "resume");
    chk("resume_addr", bus.imem_addr_o, 32'h8000_0208);
    @(negedge clk) begin rst = 1'b0; mem_lat = 1; end
    #2;
    chk("midrst_req", {31'b0, bus.imem_req_o}, 32'h0);
    chk("midrst_valid", {31'b0, bus.valid_o}, 32'h0);
    chk("midrst_pc", bus.pc_o, 32'h0);
    chk("midrst_inst", bus.inst_o, 32'h0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    wait_req(20, "post_rst");
    chk("post_rst_addr", bus.imem_addr_o, 32'h8000_0000);
    wait_valid(20, "post_rst_valid");
    chk("post_rst_pc", bus.pc_o, 32'h8000_0000);
    chk("post_rst_inst", bus.inst_o, 32'h9000_0013);
    @(negedge clk) bus.ready_i = 1'b1;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
